// File: rtl/alu_flags_stage.sv
// rtl/alu_flags_stage.sv - adder result/NZCV flag stage with 2-entry output buffer
module alu_flags_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_op,
  input  logic             in_setf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_nzcv,
  output logic [3:0]       flags_nzcv,
  output logic             flag_c
);

  logic [WIDTH-1:0] res_q [0:1];
  logic [3:0]       nzcv_q [0:1];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [3:0]       flags_q, flags_d;

  logic             push, pop;
  logic             n_new, z_new, c_new, v_new;
  logic [3:0]       nzcv_new;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);

  // Flush cancels both a same-cycle accept and a same-cycle pop.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // NZCV derivation; for subtract the operand b is un-inverted, so the
  // overflow test compares sign bits for inequality instead of equality.
  always_comb begin
    n_new = in_sum[WIDTH-1];
    z_new = (in_sum == '0);
    c_new = in_cout;
    if (in_op) begin
      v_new = (in_a_msb != in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
    end else begin
      v_new = (in_a_msb == in_b_msb) && (in_sum[WIDTH-1] != in_a_msb);
    end
    nzcv_new = {n_new, z_new, c_new, v_new};
  end

  // Pointer, occupancy and architectural flag next-state.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    flags_d = flags_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end else begin
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      if (push && in_setf) flags_d = nzcv_new;
    end
  end

  // Control and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      flags_q <= 4'd0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      flags_q <= flags_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        nzcv_q[i] <= 4'd0;
      end
    end else if (push) begin
      res_q[tail_q]  <= in_sum;
      nzcv_q[tail_q] <= nzcv_new;
    end
  end

  assign out_result = res_q[head_q];
  assign out_nzcv   = nzcv_q[head_q];
  assign flags_nzcv = flags_q;
  assign flag_c     = flags_q[1];

endmodule

// File: doc/alu_flags_stage.md
# alu_flags_stage

Registered result/flag stage directly downstream of the 32-bit add/subtract datapath (ADD/ADCS/SUBS). It captures the adder sum and carry-out and derives the NZCV condition flags. It holds an architectural flags register whose C bit feeds back as the adder's carry-in for ADCS. Results leave through a 2-entry valid/ready buffer toward writeback.

## Interface
- `WIDTH`, 32: datapath width; flag logic uses bit `WIDTH-1` as the sign bit.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; empties the buffer, flags register untouched.
- `in_valid`  in  1  upstream offers a result this cycle.
- `in_ready`  out  1  stage can accept; equals (count < 2).
- `in_sum`  in  WIDTH  adder sum `s`.
- `in_cout`  in  1  adder carry-out.
- `in_a_msb`, `in_b_msb`  in  1 each  MSB of the original (un-inverted) operands a and b.
- `in_op`  in  1  0 = add (ADD/ADCS), 1 = subtract (SUBS).
- `in_setf`  in  1  1 = update the flags register with this result.
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_result`  out  WIDTH  head entry result.
- `out_nzcv`  out  4  head entry flags {N,Z,C,V}, computed for every entry regardless of `in_setf`.
- `flags_nzcv`  out  4  architectural flags register.
- `flag_c`  out  1  `flags_nzcv[1]`; drives the adder `c_in`.

## Operation
- Accept on an edge where `in_valid && in_ready`. Pop on an edge where `out_valid && out_ready`.
- Flag derivation at accept:
  - N = `in_sum[WIDTH-1]`.
  - Z = (`in_sum` == 0).
  - C = `in_cout` for both add and subtract; for subtract, C=1 means no borrow.
  - V (add) = (`in_a_msb` == `in_b_msb`) && (`in_sum[WIDTH-1]` != `in_a_msb`).
  - V (subtract) = (`in_a_msb` != `in_b_msb`) && (`in_sum[WIDTH-1]` != `in_a_msb`).
- Flags register:
  - Loads the derived NZCV at accept when `in_setf`=1.
  - Otherwise holds its value.
  - Never changed by pop or `flush`.
- Buffer:
  - 2-entry FIFO (head/tail pointers, 2-bit count) storing {result, nzcv}. Strict in-order.
  - Push and pop on the same edge: count unchanged.
  - When count=2, `in_ready`=0, so no push is possible.
  - Pop when empty is impossible (`out_valid`=0).
- `flush`:
  - Count and pointers go to 0.
  - A same-cycle accept is discarded: no buffer entry and no flag update.
  - `flush` takes priority over push and pop.
- Reset (asynchronous, `rst_n`=0):
  - count=0, pointers=0, `out_valid`=0, `out_result`=0, `out_nzcv`=0, `flags_nzcv`=0, `flag_c`=0, `in_ready`=1.
  - Reset mid-transfer drops all buffered entries.

## Timing
- Latency: 1 cycle. An entry accepted at edge k is presented with `out_valid`=1 from edge k onward when the buffer was empty.
- `flags_nzcv` / `flag_c` reflect an accepted `in_setf` result from the edge after acceptance. A back-to-back ADCS in the next cycle sees the updated C.
- `in_ready` is a function of registered count only; there is no combinational path from `out_ready`. Full throughput requires count ≤ 1.
- Output data is held stable while `out_valid`=1 and `out_ready`=0.
- Reset deassertion is synchronized externally; the block requires no idle cycles after it.

## Test plan
- Add overflow: `in_sum`=0x80000000, `in_cout`=0, a_msb=0, b_msb=0, op=0, setf=1 -> `out_nzcv`=1001, `flags_nzcv`=1001 next cycle.
- SUBS equal: 5-5 gives `in_sum`=0, `in_cout`=1, a_msb=0, b_msb=0, op=1 -> nzcv=0110, `flag_c`=1.
- SUBS borrow: 0-1 gives `in_sum`=0xFFFFFFFF, `in_cout`=0, a_msb=0, b_msb=0, op=1 -> nzcv=1000. A setf=0 entry that follows leaves `flags_nzcv`=1000.
- Backpressure:
  - Stimulus: `out_ready`=0, offer results 0x1, 0x2, 0x3 on consecutive cycles.
  - Required: `in_ready` falls after the 2nd accept; 0x3 is held upstream.
  - Then raise `out_ready`: outputs 0x1, 0x2, 0x3 in order, with no loss or duplication.
- Simultaneous push/pop at count=1: count stays 1 and order is preserved across 8 streaming results.
- Flush and reset:
  - Stimulus: two entries buffered with `flags_nzcv`=0100, then `flush`=1 with a concurrent setf accept.
  - Required: `out_valid`=0, `flags_nzcv` stays 0100.
  - Then assert `rst_n`=0 mid-stream: all outputs 0 and `in_ready`=1 immediately, without waiting for a clock edge.
